// File: rtl/cdc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdc_pkg
// Description : Shared types and constants for the req/ack clock-crossing
//               source controller.
//               cdc_tx_state_t : source-side FSM states (IDLE, REQ, REL)
//               XFER_CNT_W     : width of the completed-transfer counter
// Revision    : 1.0  initial release
// ============================================================================
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } cdc_tx_state_t;

  localparam int XFER_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/half_synchronizer.sv
`default_nettype none
// ============================================================================
// Module      : half_synchronizer
// Description : W-stage flop synchronizer for one asynchronous level, with
//               single-cycle edge indications on the synchronized level.
//               No reset: the chain simply flushes to the input level.
// Ports       : clk        in   destination clock (posedge)
//               d          in   asynchronous level
//               out        out  synchronized level, follows d after W edges
//               rise_edge  out  1 for the first cycle out is 1 after a 0
//               fall_edge  out  1 for the first cycle out is 0 after a 1
// Parameters  : W  number of synchronizer stages (W >= 2)
// Revision    : 1.0  initial release
// ============================================================================
module half_synchronizer #(
  parameter int W = 3
) (
  input  logic clk,
  input  logic d,
  output logic out,
  output logic rise_edge,
  output logic fall_edge
);

  logic [W-1:0] r_sync;
  logic         r_out_q;

  always_ff @(posedge clk) begin
    r_sync  <= {r_sync[W-2:0], d};
    r_out_q <= r_sync[W-1];
  end

  assign out       = r_sync[W-1];
  assign rise_edge = r_sync[W-1] & ~r_out_q;
  assign fall_edge = ~r_sync[W-1] & r_out_q;

endmodule
`default_nettype wire

// File: rtl/cdc_req_ack_tx.sv
`default_nettype none
// ============================================================================
// Module      : cdc_req_ack_tx
// Description : Source-side controller for a 4-phase level req/ack crossing.
//               Accepts one word on a valid/ready port, holds it on x_data,
//               raises x_req, waits for the synchronized acknowledge, then
//               drops x_req and waits for the acknowledge to return low.
//               An optional timeout abandons a request that is never acked.
// Ports       : aclk      in   clock, all logic on posedge
//               aresetn   in   asynchronous active-low reset
//               s_valid   in   word offered
//               s_ready   out  word accepted when s_valid & s_ready
//               s_data    in   word to transfer
//               x_req     out  request level to far domain
//               x_data    out  held word, stable while x_req = 1
//               x_ack     in   acknowledge level from far domain (async)
//               to_limit  in   aclk cycles allowed in REQ, 0 disables
//               err_clr   in   clears err
//               done      out  1-cycle pulse, word acknowledged
//               timeout   out  1-cycle pulse, request abandoned
//               err       out  sticky timeout flag
//               xfer_cnt  out  completed transfers, wraps
// Parameters  : DW      data width
//               SYNC_W  acknowledge synchronizer depth
//               TO_W    timeout counter width
// Revision    : 1.0  initial release
// ============================================================================
module cdc_req_ack_tx
  import cdc_pkg::*;
#(
  parameter int DW     = 32,
  parameter int SYNC_W = 3,
  parameter int TO_W   = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DW-1:0]         s_data,
  output logic                  x_req,
  output logic [DW-1:0]         x_data,
  input  logic                  x_ack,
  input  logic [TO_W-1:0]       to_limit,
  input  logic                  err_clr,
  output logic                  done,
  output logic                  timeout,
  output logic                  err,
  output logic [XFER_CNT_W-1:0] xfer_cnt
);

  localparam logic [TO_W-1:0]       c_to_one   = TO_W'(1);
  localparam logic [XFER_CNT_W-1:0] c_xfer_one = XFER_CNT_W'(1);

  cdc_tx_state_t         r_state;
  logic                  r_x_req;
  logic [DW-1:0]         r_x_data;
  logic                  r_done;
  logic                  r_timeout;
  logic                  r_err;
  logic [XFER_CNT_W-1:0] r_xfer_cnt;
  logic [TO_W-1:0]       r_cnt;

  logic w_ack_s;
  logic w_ack_r;
  logic w_ack_f;
  logic w_to_hit;
  logic w_unused;

  half_synchronizer #(
    .W (SYNC_W)
  ) u_ack_sync (
    .clk       (aclk),
    .d         (x_ack),
    .out       (w_ack_s),
    .rise_edge (w_ack_r),
    .fall_edge (w_ack_f)
  );

  // The FSM acts on the synchronized level; the edge strobes are kept on the
  // synchronizer for observation but are not needed here.
  assign w_unused = w_ack_r ^ w_ack_f;

  // Last permitted REQ cycle; a zero limit never matches.
  assign w_to_hit = (to_limit != '0) && (r_cnt == (to_limit - c_to_one));

  // A stale acknowledge (e.g. reset while the far side was still acking)
  // keeps the port closed until the far side has released.
  always_comb begin
    s_ready = (r_state == IDLE) && !w_ack_s;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= IDLE;
      r_x_req    <= 1'b0;
      r_x_data   <= '0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_err      <= 1'b0;
      r_xfer_cnt <= '0;
      r_cnt      <= '0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      // A timeout below in the same cycle overrides this clear.
      if (err_clr) begin
        r_err <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (s_valid && s_ready) begin
            r_x_data <= s_data;
            r_x_req  <= 1'b1;
            r_cnt    <= '0;
            r_state  <= REQ;
          end
        end

        REQ: begin
          // Acknowledge takes priority over a coincident timeout.
          if (w_ack_s) begin
            r_x_req    <= 1'b0;
            r_done     <= 1'b1;
            r_xfer_cnt <= r_xfer_cnt + c_xfer_one;
            r_state    <= REL;
          end else if (w_to_hit) begin
            r_x_req   <= 1'b0;
            r_timeout <= 1'b1;
            r_err     <= 1'b1;
            r_state   <= REL;
          end else begin
            r_cnt <= r_cnt + c_to_one;
          end
        end

        REL: begin
          // Also absorbs a late acknowledge after a timeout.
          if (!w_ack_s) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign x_req    = r_x_req;
  assign x_data   = r_x_data;
  assign done     = r_done;
  assign timeout  = r_timeout;
  assign err      = r_err;
  assign xfer_cnt = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cdc_req_ack_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdc_req_ack_tx
// Description : Self-checking bench for cdc_req_ack_tx. A transaction-level
//               model predicts every output each cycle; directed scenarios add
//               hand-computed expectations (pulse counts, latencies, limits).
// Revision    : 1.0  initial release
// ============================================================================
module tb_cdc_req_ack_tx;

  localparam int DW     = 32;
  localparam int SYNC_W = 3;
  localparam int TO_W   = 16;

  logic            aclk     = 1'b0;
  logic            aresetn  = 1'b0;
  logic            s_valid  = 1'b0;
  logic [DW-1:0]   s_data   = '0;
  logic            x_ack    = 1'b0;
  logic [TO_W-1:0] to_limit = '0;
  logic            err_clr  = 1'b0;
  logic            s_ready;
  logic            x_req;
  logic [DW-1:0]   x_data;
  logic            done;
  logic            timeout;
  logic            err;
  logic [15:0]     xfer_cnt;

  always #5 aclk = ~aclk;

  cdc_req_ack_tx #(
    .DW     (DW),
    .SYNC_W (SYNC_W),
    .TO_W   (TO_W)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .x_req    (x_req),
    .x_data   (x_data),
    .x_ack    (x_ack),
    .to_limit (to_limit),
    .err_clr  (err_clr),
    .done     (done),
    .timeout  (timeout),
    .err      (err),
    .xfer_cnt (xfer_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- model ----------------
  // phase: 0 = waiting for a word, 1 = request outstanding, 2 = releasing
  int            m_phase;
  int            m_req_cycles;
  logic          m_xreq;
  logic [DW-1:0] m_xdata;
  logic          m_done;
  logic          m_to;
  logic          m_err;
  int            m_xfer;
  logic [SYNC_W-1:0] m_ack_seen = '0;  // x_ack as seen over the last SYNC_W edges
  bit            chk_en = 0;

  // ---------------- far side / observation ----------------
  int far_mode = 0;
  int far_dly  = 0;
  int far_cnt  = 0;
  int tick_no  = 0;
  int ack_tick = -1;
  int done_tick = -1;
  int obs_done = 0;
  int obs_to   = 0;
  int obs_req_hi = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_req_cycles = 0; m_xreq = 0; m_xdata = '0;
    m_done = 0; m_to = 0; m_err = 0; m_xfer = 0;
  endtask

  // One clock edge worth of rules, applied to the inputs present at the edge.
  task automatic model_edge();
    bit acked;
    acked = m_ack_seen[SYNC_W-1];
    if (aresetn) begin
      m_done = 0;
      m_to   = 0;
      if (err_clr) m_err = 0;
      if (m_phase == 0) begin
        if (s_valid && !acked) begin
          m_xdata = s_data; m_xreq = 1; m_req_cycles = 0; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_req_cycles = m_req_cycles + 1;
        if (acked) begin
          m_xreq = 0; m_done = 1; m_xfer = (m_xfer + 1) % 65536; m_phase = 2;
        end else if (to_limit != 0 && m_req_cycles == int'(to_limit)) begin
          m_xreq = 0; m_to = 1; m_err = 1; m_phase = 2;
        end
      end else begin
        if (!acked) m_phase = 0;
      end
    end
    m_ack_seen = {m_ack_seen[SYNC_W-2:0], x_ack};
  endtask

  task automatic compare();
    if (chk_en) begin
      check("s_ready",  s_ready,  (m_phase == 0) && !m_ack_seen[SYNC_W-1]);
      check("x_req",    x_req,    m_xreq);
      check("x_data",   x_data,   m_xdata);
      check("done",     done,     m_done);
      check("timeout",  timeout,  m_to);
      check("err",      err,      m_err);
      check("xfer_cnt", xfer_cnt, m_xfer[15:0]);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    model_edge();
    tick_no++;
    #2;
    if (far_mode == 1) begin
      if (x_req && !x_ack) begin
        far_cnt++;
        if (far_cnt >= far_dly) begin
          x_ack = 1'b1;
          ack_tick = tick_no;
        end
      end else if (!x_req && x_ack) begin
        x_ack = 1'b0;
        far_cnt = 0;
      end
    end
    @(negedge aclk);
    compare();
    if (done) begin
      obs_done++;
      if (done_tick < 0) done_tick = tick_no;
    end
    if (timeout) obs_to++;
    if (x_req) obs_req_hi++;
  endtask

  task automatic clear_obs();
    obs_done = 0; obs_to = 0; obs_req_hi = 0; ack_tick = -1; done_tick = -1; far_cnt = 0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0; s_valid = 1'b0; err_clr = 1'b0; far_mode = 0; x_ack = 1'b0;
    model_reset();
    repeat (SYNC_W + 2) tick();
    aresetn = 1'b1;
    clear_obs();
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    int k;
    s_valid = 1'b1;
    s_data  = w;
    k = 0;
    while (!x_req && k < 100) begin
      tick();
      k++;
    end
    s_valid = 1'b0;
    check("accept_wait", x_req, 1'b1);
  endtask

  initial begin
    int viol;
    int idx;
    int k;
    logic prev_req;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] words [8];

    model_reset();
    do_reset();
    chk_en = 1;

    // reset state
    check("rst_x_req", x_req, 1'b0);
    check("rst_x_data", x_data, 32'h0);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_xfer_cnt", xfer_cnt, 16'h0);

    // 1: basic transfer, far side acks 4 cycles after x_req
    to_limit = '0; far_mode = 1; far_dly = 4;
    send_word(32'hA5A5_0001);
    viol = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (x_req && x_data !== 32'hA5A5_0001) viol++;
      if (obs_done >= 1 && s_ready) break;
    end
    check("t1_done_pulses", obs_done, 1);
    check("t1_xfer_cnt", xfer_cnt, 16'd1);
    check("t1_data_stable", viol, 0);
    check("t1_x_data_held", x_data, 32'hA5A5_0001);
    check("t1_ack_to_done", done_tick - ack_tick, SYNC_W + 1);
    check("t1_ready_back", s_ready, 1'b1);

    // 2: back-to-back, s_valid held with 8 words
    do_reset();
    far_mode = 1; far_dly = 2;
    for (int i = 0; i < 8; i++) words[i] = 32'h1000_0000 + i * 32'h111;
    idx = 0; viol = 0; prev_req = 0; prev_data = '0;
    s_valid = 1'b1; s_data = words[0];
    for (int i = 0; i < 500; i++) begin
      tick();
      if (x_req && !prev_req) begin
        if (x_data !== words[idx]) viol++;
        idx++;
        if (idx < 8) s_data = words[idx];
        else s_valid = 1'b0;
      end
      if (x_req && prev_req && x_data !== prev_data) viol++;
      prev_req = x_req; prev_data = x_data;
      if (obs_done == 8 && s_ready && !s_valid) break;
    end
    s_valid = 1'b0;
    check("t2_done_pulses", obs_done, 8);
    check("t2_xfer_cnt", xfer_cnt, 16'd8);
    check("t2_words_sent", idx, 8);
    check("t2_data_violations", viol, 0);

    // 3: timeout, far side silent
    do_reset();
    to_limit = 16'd10;
    send_word(32'hDEAD_0003);
    for (int i = 0; i < 40; i++) tick();
    check("t3_req_cycles", obs_req_hi, 10);
    check("t3_timeout_pulses", obs_to, 1);
    check("t3_no_done", obs_done, 0);
    check("t3_err_set", err, 1'b1);
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    check("t3_err_cleared", err, 1'b0);
    // err_clr held across a second timeout: the set wins on that edge
    clear_obs();
    send_word(32'hDEAD_0033);
    err_clr = 1'b1;
    k = 0;
    while (obs_to == 0 && k < 20) begin tick(); k++; end
    check("t3_set_wins", err, 1'b1);
    err_clr = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    // 4: late ack at cycle 20 after a 10-cycle timeout
    do_reset();
    to_limit = 16'd10;
    send_word(32'hBEEF_0004);
    for (k = 1; k <= 32; k++) begin
      tick();
      if (k == 19) x_ack = 1'b1;
      if (k == 24) check("t4_stale_ack_blocks", s_ready, 1'b0);
      if (k == 25) x_ack = 1'b0;
    end
    check("t4_no_done", obs_done, 0);
    check("t4_timeout_once", obs_to, 1);
    check("t4_xfer_unchanged", xfer_cnt, 16'd0);
    check("t4_ready_back", s_ready, 1'b1);

    // 5: ack_s rises in the last permitted REQ cycle
    do_reset();
    to_limit = 16'd10;
    send_word(32'hC0DE_0005);
    repeat (6) tick();
    x_ack = 1'b1;
    k = 0;
    while (obs_done == 0 && obs_to == 0 && k < 12) begin tick(); k++; end
    x_ack = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("t5_done", obs_done, 1);
    check("t5_no_timeout", obs_to, 0);
    check("t5_err_clear", err, 1'b0);
    check("t5_xfer_cnt", xfer_cnt, 16'd1);

    // 6: reset mid-REQ with x_ack held high
    do_reset();
    to_limit = '0;
    send_word(32'h6666_0006);
    x_ack = 1'b1;
    repeat (SYNC_W) tick();
    aresetn = 1'b0;
    model_reset();
    #1;
    check("t6_x_req_drop", x_req, 1'b0);
    check("t6_x_data_zero", x_data, 32'h0);
    check("t6_outputs_zero", {done, timeout, err}, 3'b000);
    check("t6_xfer_zero", xfer_cnt, 16'h0);
    check("t6_done_not_seen", obs_done, 0);
    repeat (4) tick();
    aresetn = 1'b1;
    tick();
    check("t6_stale_blocks", s_ready, 1'b0);
    x_ack = 1'b0;
    k = 0;
    while (k < 10) begin
      tick();
      k++;
      if (s_ready) break;
    end
    check("t6_ready_edges", k, SYNC_W);

    // 7: transfer counter wraps 0xFFFF -> 0
    do_reset();
    force dut.r_xfer_cnt = 16'hFFFF;
    #1;
    release dut.r_xfer_cnt;
    m_xfer = 65535;
    tick();
    check("t7_preload", xfer_cnt, 16'hFFFF);
    far_mode = 1; far_dly = 2;
    send_word(32'h7777_0007);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (obs_done >= 1 && s_ready) break;
    end
    check("t7_wrap", xfer_cnt, 16'h0000);
    check("t7_done", obs_done, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
